// File: rtl/md_unit_pkg.sv
// Shared md_op encodings and the combinational multiply/divide datapath
// used by the controller and md_unit.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_md_start(md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_md_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps instead of trapping.
    function automatic hilo_t md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
        hilo_t       res;
        logic [63:0] prod;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] q;
        logic [31:0] r;
        res  = '0;
        prod = '0;
        ua   = a[31] ? (32'd0 - a) : a;
        ub   = b[31] ? (32'd0 - b) : b;
        q    = '0;
        r    = '0;
        case (op)
            MD_MULT: begin
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res  = prod;
            end
            MD_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = prod;
            end
            MD_DIV: begin
                q      = ua / ub;
                r      = ua % ub;
                res.lo = (a[31] ^ b[31]) ? (32'd0 - q) : q;
                res.hi = a[31] ? (32'd0 - r) : r;
            end
            MD_DIVU: begin
                res.lo = a / b;
                res.hi = a % b;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/result bundle between the EX forwarding muxes, hazard unit and md_unit.
interface md_unit_if;
    import md_unit_pkg::*;

    md_op_e      md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output md_op, a, b, input busy, hi, lo);
    modport slave  (input md_op, a, b, output busy, hi, lo);

endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; the result is computed
// at start and held in a pending register until the latency counter expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset,
    md_unit_if.slave bus
);

    localparam int unsigned MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);

    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic             div_zero;
    hilo_t            pending;
    hilo_t            hilo;

    logic             start;
    logic             finishing;
    logic [CNT_W-1:0] start_n;
    hilo_t            start_res;

    always_comb begin
        finishing = busy_q && (count == CNT_W'(1));
        start     = is_md_start(bus.md_op) && (!busy_q || finishing);
        start_n   = is_md_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        start_res = md_compute(bus.md_op, bus.a, bus.b);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            count    <= '0;
            div_zero <= 1'b0;
            pending  <= '0;
            hilo     <= '0;
        end else begin
            if (busy_q) begin
                if (finishing) begin
                    busy_q <= 1'b0;
                    count  <= '0;
                    if (!div_zero) begin
                        hilo <= pending;
                    end
                end else begin
                    count <= count - 1'b1;
                end
            end else begin
                case (bus.md_op)
                    MD_MTHI: hilo.hi <= bus.a;
                    MD_MTLO: hilo.lo <= bus.a;
                    default: ;
                endcase
            end
            // A start on the completion edge overrides the idle transition above.
            if (start) begin
                busy_q   <= 1'b1;
                count    <= start_n;
                pending  <= start_res;
                div_zero <= is_md_div(bus.md_op) && (bus.b == 32'd0);
            end
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hilo.hi;
    assign bus.lo   = hilo.lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed scoreboard bench for md_unit: expected HI/LO are queued at issue and
// checked when busy drops; outputs are sampled on the falling clock edge.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned NM = 5;
    localparam int unsigned ND = 10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    hilo_t sb[$];

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at the first falling edge after the start edge; returns at the falling edge after completion.
    task automatic wait_done(input string tag, input int n);
        hilo_t r;
        int    cyc;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 64) begin
            chk({tag, "_hold_hi"}, bus.hi, hi_m);
            chk({tag, "_hold_lo"}, bus.lo, lo_m);
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk({tag, "_hi"}, bus.hi, r.hi);
            chk({tag, "_lo"}, bus.lo, r.lo);
            hi_m = r.hi;
            lo_m = r.lo;
        end else begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end
    endtask

    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int n);
        sb.push_back('{hi: eh, lo: el});
        @(negedge clk);
        bus.md_op = op;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.md_op = MD_NONE;
        wait_done(tag, n);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        hi_m        = '0;
        lo_m        = '0;
        reset       = 1'b1;
        bus.md_op   = MD_NONE;
        bus.a       = '0;
        bus.b       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);

        run_op("mult_3x4", MD_MULT, 32'd3, 32'd4, 32'd0, 32'd12, NM);
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NM);
        run_op("multu", MD_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, NM);
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, ND);
        run_op("divu_7_2", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, ND);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, ND);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, ND);

        // MTHI / MTLO while idle take effect at the sampling edge with no busy cycle.
        @(negedge clk);
        bus.md_op = MD_MTHI;
        bus.a     = 32'h0000_1234;
        @(negedge clk);
        bus.md_op = MD_NONE;
        chk("mthi_hi", bus.hi, 32'h0000_1234);
        chk("mthi_lo", bus.lo, lo_m);
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        hi_m = 32'h0000_1234;

        run_op("divu_by0", MD_DIVU, 32'd5, 32'd0, hi_m, lo_m, ND);

        @(negedge clk);
        bus.md_op = MD_MTLO;
        bus.a     = 32'h0000_BEEF;
        @(negedge clk);
        bus.md_op = MD_NONE;
        chk("mtlo_lo", bus.lo, 32'h0000_BEEF);
        chk("mtlo_busy", 32'(bus.busy), 32'd0);
        lo_m = 32'h0000_BEEF;

        // MTLO during busy is ignored; a second MULT lands on the completion edge.
        sb.push_back('{hi: 32'd0, lo: 32'd42});
        @(negedge clk);
        bus.md_op = MD_MULT;
        bus.a     = 32'd6;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.md_op = MD_MTLO;
        bus.a     = 32'h0000_DEAD;
        @(negedge clk);
        bus.md_op = MD_NONE;
        chk("mtlo_busy_ignored", bus.lo, lo_m);
        chk("mtlo_busy_still", 32'(bus.busy), 32'd1);
        repeat (NM - 2) @(negedge clk);
        sb.push_back('{hi: 32'd1, lo: 32'd0});
        bus.md_op = MD_MULT;
        bus.a     = 32'h0001_0000;
        bus.b     = 32'h0001_0000;
        @(negedge clk);
        bus.md_op = MD_NONE;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        begin
            hilo_t r;
            r = sb.pop_front();
            chk("b2b_first_hi", bus.hi, r.hi);
            chk("b2b_first_lo", bus.lo, r.lo);
            hi_m = r.hi;
            lo_m = r.lo;
        end
        wait_done("b2b_second", NM);

        // Reset on the third busy cycle of a DIV aborts it with no late write.
        @(negedge clk);
        bus.md_op = MD_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.md_op = MD_NONE;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);
        repeat (ND + 2) @(negedge clk);
        chk("rst_late_busy", 32'(bus.busy), 32'd0);
        chk("rst_late_hi", bus.hi, 32'd0);
        chk("rst_late_lo", bus.lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
